// File: rtl/i2c_sequencer_pkg.sv
// Shared types for the i2c_master command front-end: sequencer states and the
// default-width command layout (7-bit device, 8-bit register, 8-bit data).
package i2c_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESPOND
  } seq_state_e;

  localparam int CMD_ADDRESS_WIDTH  = 7;
  localparam int CMD_REGISTER_WIDTH = 8;
  localparam int CMD_DATA_WIDTH     = 8;

  typedef struct packed {
    logic                          rw;
    logic [CMD_ADDRESS_WIDTH-1:0]  device;
    logic [CMD_REGISTER_WIDTH-1:0] register_address;
    logic [CMD_DATA_WIDTH-1:0]     data;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_command_fifo.sv
// Synchronous command FIFO with registered full/empty and a first-word view of
// the head entry. DEPTH must be a power of two so the pointers wrap naturally.
module i2c_command_fifo
  import i2c_sequencer_pkg::*;
#(
  parameter type cmd_t = i2c_cmd_t,
  parameter int  DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  // Push and pop in the same cycle both take effect; count stays put.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    full_d   = (count_d == (PW+1)'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/i2c_command_sequencer.sv
// Queues I2C transaction requests and runs them through i2c_master one at a
// time: enable handshake, wait for busy, then one response per command.
module i2c_command_sequencer
  import i2c_sequencer_pkg::*;
#(
  parameter int NUMBER_OF_DATA_BYTES     = 1,
  parameter int NUMBER_OF_REGISTER_BYTES = 1,
  parameter int ADDRESS_WIDTH            = 7,
  parameter int FIFO_DEPTH               = 4,
  parameter int START_TIMEOUT            = 255
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  command_valid,
  output logic                                  command_ready,
  input  logic                                  command_read_write,
  input  logic [ADDRESS_WIDTH-1:0]              command_device_address,
  input  logic [8*NUMBER_OF_REGISTER_BYTES-1:0] command_register_address,
  input  logic [8*NUMBER_OF_DATA_BYTES-1:0]     command_data,
  output logic                                  response_valid,
  input  logic                                  response_ready,
  output logic                                  response_read_write,
  output logic [8*NUMBER_OF_DATA_BYTES-1:0]     response_data,
  output logic                                  response_error,
  output logic                                  master_enable,
  output logic                                  master_read_write,
  output logic [8*NUMBER_OF_DATA_BYTES-1:0]     master_mosi_data,
  output logic [8*NUMBER_OF_REGISTER_BYTES-1:0] master_register_address,
  output logic [ADDRESS_WIDTH-1:0]              master_device_address,
  input  logic                                  master_busy,
  input  logic [8*NUMBER_OF_DATA_BYTES-1:0]     master_miso_data,
  output logic                                  idle
);

  localparam int DATA_WIDTH     = 8 * NUMBER_OF_DATA_BYTES;
  localparam int REGISTER_WIDTH = 8 * NUMBER_OF_REGISTER_BYTES;
  localparam int TIMER_W        = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(START_TIMEOUT);

  typedef struct packed {
    logic                      rw;
    logic [ADDRESS_WIDTH-1:0]  device;
    logic [REGISTER_WIDTH-1:0] register_address;
    logic [DATA_WIDTH-1:0]     data;
  } seq_cmd_t;

  seq_cmd_t push_cmd, head_cmd;
  logic     fifo_full, fifo_empty, fifo_pop;

  seq_state_e                state_q, state_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic                      enable_q, enable_d;
  logic                      m_rw_q, m_rw_d;
  logic [ADDRESS_WIDTH-1:0]  m_dev_q, m_dev_d;
  logic [REGISTER_WIDTH-1:0] m_reg_q, m_reg_d;
  logic [DATA_WIDTH-1:0]     m_data_q, m_data_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_rw_q, rsp_rw_d;
  logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;

  always_comb begin
    push_cmd.rw               = command_read_write;
    push_cmd.device           = command_device_address;
    push_cmd.register_address = command_register_address;
    push_cmd.data             = command_data;
  end

  i2c_command_fifo #(
    .cmd_t (seq_cmd_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (command_valid),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .head      (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    enable_d    = enable_q;
    m_rw_d      = m_rw_q;
    m_dev_d     = m_dev_q;
    m_reg_d     = m_reg_q;
    m_data_d    = m_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rw_d    = rsp_rw_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      // Enable is raised on entry to ISSUE so it is visible two cycles after the push.
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          m_rw_d   = head_cmd.rw;
          m_dev_d  = head_cmd.device;
          m_reg_d  = head_cmd.register_address;
          m_data_d = head_cmd.data;
          enable_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (master_busy) begin
          enable_d = 1'b0;
          state_d  = WAIT_DONE;
        end else if (timer_q == TIMER_LIMIT) begin
          enable_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rw_d    = m_rw_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESPOND;
        end else if (timer_q != {TIMER_W{1'b1}}) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!master_busy) begin
          rsp_valid_d = 1'b1;
          rsp_rw_d    = m_rw_q;
          rsp_data_d  = m_rw_q ? master_miso_data : '0;
          rsp_err_d   = 1'b0;
          state_d     = RESPOND;
        end
      end
      // No response queue: the next command waits here until this one is taken.
      RESPOND: begin
        if (response_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      enable_q    <= 1'b0;
      m_rw_q      <= 1'b0;
      m_dev_q     <= '0;
      m_reg_q     <= '0;
      m_data_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rw_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      enable_q    <= enable_d;
      m_rw_q      <= m_rw_d;
      m_dev_q     <= m_dev_d;
      m_reg_q     <= m_reg_d;
      m_data_q    <= m_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rw_q    <= rsp_rw_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign command_ready           = !fifo_full;
  assign idle                    = fifo_empty && (state_q == IDLE);
  assign master_enable           = enable_q;
  assign master_read_write       = m_rw_q;
  assign master_device_address   = m_dev_q;
  assign master_register_address = m_reg_q;
  assign master_mosi_data        = m_data_q;
  assign response_valid          = rsp_valid_q;
  assign response_read_write     = rsp_rw_q;
  assign response_data           = rsp_data_q;
  assign response_error          = rsp_err_q;

endmodule
